// File: rtl/spi_master_fifo_thr_if.sv
// ---------------------------------------------------------------------------
// spi_master_fifo_thr_if
//   Bundles the push side, pop side, control and status signals of one
//   spi_master_fifo_thr instance.
//
//   slave  modport : the FIFO itself
//   master modport : the producer/consumer/controller surrounding the FIFO
//
//   Push side : valid_i, data_i, ready_o
//   Pop side  : valid_o, data_o, ready_i
//   Control   : clr_i (flush), err_clr_i (clear overflow)
//   Status    : elements_o, free_o, almost_full_o, almost_empty_o, overflow_o
// ---------------------------------------------------------------------------
interface spi_master_fifo_thr_if #(
    parameter int DATA_WIDTH   = 32,
    parameter int BUFFER_DEPTH = 8
);
    localparam int LOG_BUFFER_DEPTH = $clog2(BUFFER_DEPTH);

    logic                      clr_i;
    logic                      err_clr_i;
    logic                      valid_i;
    logic [DATA_WIDTH-1:0]     data_i;
    logic                      ready_o;
    logic                      valid_o;
    logic [DATA_WIDTH-1:0]     data_o;
    logic                      ready_i;
    logic [LOG_BUFFER_DEPTH:0] elements_o;
    logic [LOG_BUFFER_DEPTH:0] free_o;
    logic                      almost_full_o;
    logic                      almost_empty_o;
    logic                      overflow_o;

    modport slave (
        input  clr_i, err_clr_i, valid_i, data_i, ready_i,
        output ready_o, valid_o, data_o, elements_o, free_o,
               almost_full_o, almost_empty_o, overflow_o
    );

    modport master (
        output clr_i, err_clr_i, valid_i, data_i, ready_i,
        input  ready_o, valid_o, data_o, elements_o, free_o,
               almost_full_o, almost_empty_o, overflow_o
    );
endinterface

// File: rtl/spi_master_fifo_thr.sv
// ---------------------------------------------------------------------------
// spi_master_fifo_thr
//   Synchronous FIFO of arbitrary depth for the SPI master datapath (TX data,
//   RX data and command queues). Provides occupancy and free-space counts,
//   programmable almost-full / almost-empty flags, a sticky overflow flag and
//   an optional fall-through mode in which an empty FIFO forwards data_i to
//   data_o in the same cycle.
//
//   Ports:
//     clk_i : clock, rising edge
//     rst_i : synchronous active-high reset (control state only; the storage
//             array is never reset)
//     bus   : spi_master_fifo_thr_if.slave
//               push    valid_i / data_i / ready_o
//               pop     valid_o / data_o / ready_i
//               control clr_i (flush), err_clr_i (clear overflow)
//               status  elements_o, free_o, almost_full_o, almost_empty_o,
//                       overflow_o
// ---------------------------------------------------------------------------
module spi_master_fifo_thr #(
    parameter int DATA_WIDTH      = 32,
    parameter int BUFFER_DEPTH    = 8,
    parameter int ALMOST_FULL_TH  = BUFFER_DEPTH - 1,
    parameter int ALMOST_EMPTY_TH = 1,
    parameter bit FALL_THROUGH    = 1'b0
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    spi_master_fifo_thr_if.slave      bus
);
    localparam int LOG_BUFFER_DEPTH = $clog2(BUFFER_DEPTH);
    localparam int CNT_W            = LOG_BUFFER_DEPTH + 1;

    localparam logic [CNT_W-1:0]            DEPTH_C = CNT_W'(BUFFER_DEPTH);
    localparam logic [CNT_W-1:0]            AF_TH_C = CNT_W'(ALMOST_FULL_TH);
    localparam logic [CNT_W-1:0]            AE_TH_C = CNT_W'(ALMOST_EMPTY_TH);
    localparam logic [LOG_BUFFER_DEPTH-1:0] LAST_C  = LOG_BUFFER_DEPTH'(BUFFER_DEPTH - 1);

    // Pointers wrap explicitly at BUFFER_DEPTH-1 so any depth works, not just
    // powers of two.
    function automatic logic [LOG_BUFFER_DEPTH-1:0] ptr_next(
        input logic [LOG_BUFFER_DEPTH-1:0] ptr
    );
        if (ptr == LAST_C) begin
            return '0;
        end
        return ptr + 1'b1;
    endfunction

    logic [DATA_WIDTH-1:0]       storage [BUFFER_DEPTH];
    logic [LOG_BUFFER_DEPTH-1:0] wr_ptr_q;
    logic [LOG_BUFFER_DEPTH-1:0] rd_ptr_q;
    logic [CNT_W-1:0]            elements_q;
    logic                        overflow_q;

    logic full;
    logic empty;
    logic ft_active;
    logic ready;
    logic valid;
    logic push;
    logic pop;
    logic bypass;
    logic push_store;
    logic pop_store;

    assign full  = (elements_q == DEPTH_C);
    assign empty = (elements_q == '0);

    // Fall-through path is only live while the FIFO is empty and not being
    // flushed; the word on data_i is then the head of the queue.
    assign ft_active = FALL_THROUGH && empty && !bus.clr_i;

    assign ready = !full && !bus.clr_i;
    assign valid = ft_active ? bus.valid_i : (!empty && !bus.clr_i);

    assign push = bus.valid_i && ready;
    assign pop  = valid && bus.ready_i;

    // A fall-through word taken in the same cycle never touches storage, so
    // neither the pointers nor the occupancy move.
    assign bypass     = ft_active && bus.valid_i && bus.ready_i;
    assign push_store = push && !bypass;
    assign pop_store  = pop && !bypass;

    assign bus.ready_o        = ready;
    assign bus.valid_o        = valid;
    assign bus.data_o         = ft_active ? bus.data_i : storage[rd_ptr_q];
    assign bus.elements_o     = elements_q;
    assign bus.free_o         = DEPTH_C - elements_q;
    assign bus.almost_full_o  = (elements_q >= AF_TH_C);
    assign bus.almost_empty_o = (elements_q <= AE_TH_C);
    assign bus.overflow_o     = overflow_q;

    // Control state: pointers, occupancy and overflow flag.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            elements_q <= '0;
            overflow_q <= 1'b0;
        end else if (bus.clr_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            elements_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push_store) begin
                wr_ptr_q <= ptr_next(wr_ptr_q);
            end
            if (pop_store) begin
                rd_ptr_q <= ptr_next(rd_ptr_q);
            end
            case ({push_store, pop_store})
                2'b10:   elements_q <= elements_q + 1'b1;
                2'b01:   elements_q <= elements_q - 1'b1;
                default: elements_q <= elements_q;
            endcase
            // A new overflow wins over a clear request in the same cycle.
            if (bus.valid_i && full) begin
                overflow_q <= 1'b1;
            end else if (bus.err_clr_i) begin
                overflow_q <= 1'b0;
            end
        end
    end

    // Data storage: written on stored pushes only, never reset.
    always_ff @(posedge clk_i) begin
        if (push_store) begin
            storage[wr_ptr_q] <= bus.data_i;
        end
    end
endmodule

// File: doc/spi_master_fifo_thr.md
# spi_master_fifo_thr

Parametrised synchronous FIFO for the SPI master datapath, replacing the fixed two-entry buffer between the APB register file and the SPI TX/RX controllers. It adds arbitrary (non-power-of-two) depth, programmable almost-full/almost-empty thresholds, a free-space count, an optional zero-latency fall-through mode and a sticky overflow flag. It is used for TX data, RX data and command queues, each instance with its own parameters.

## Interface
- DATA_WIDTH, 32, payload width in bits (>=1)
- BUFFER_DEPTH, 8, number of entries (>=2, any integer)
- LOG_BUFFER_DEPTH, ceil(log2(BUFFER_DEPTH)), pointer width (derived, not overridden)
- ALMOST_FULL_TH, BUFFER_DEPTH-1, almost_full_o asserts when elements >= this value
- ALMOST_EMPTY_TH, 1, almost_empty_o asserts when elements <= this value
- FALL_THROUGH, 0, 1 = an empty FIFO presents data_i combinationally on data_o
- clk_i  in  1  clock; all logic is on the rising edge
- rst_i  in  1  reset; **one clock; reset is synchronous and active-high**
- clr_i  in  1  synchronous flush of contents and pointers
- err_clr_i  in  1  clears overflow_o
- valid_i  in  1  push request
- data_i  in  DATA_WIDTH  push data
- ready_o  out  1  FIFO can accept a push
- valid_o  out  1  data_o holds a valid entry
- data_o  out  DATA_WIDTH  head entry
- ready_i  in  1  consumer accepts the head entry
- elements_o  out  LOG_BUFFER_DEPTH+1  current occupancy
- free_o  out  LOG_BUFFER_DEPTH+1  BUFFER_DEPTH - elements
- almost_full_o  out  1  threshold flag
- almost_empty_o  out  1  threshold flag
- overflow_o  out  1  sticky: push attempted while full

## Operation
- Push accepted: valid_i && ready_o. Pop accepted: valid_o && ready_i.
- ready_o = !full && !clr_i. full = (elements == BUFFER_DEPTH).
- Stored mode: valid_o = (elements != 0) && !clr_i. data_o = storage[rd_ptr].
- Fall-through (FALL_THROUGH=1, elements==0, !clr_i): valid_o = valid_i and data_o = data_i. If ready_i is also high, the word bypasses storage: pointers and elements are unchanged. If ready_i is low, the word is written normally.
- Pointers: wr_ptr advances on every stored push and rd_ptr on every stored pop. Each wraps from BUFFER_DEPTH-1 to 0; there is no power-of-two assumption.
- elements: +1 on push only, -1 on pop only, unchanged on simultaneous push+pop. Push+pop while full cannot occur because ready_o=0.
- elements never exceeds BUFFER_DEPTH and never underflows. free_o is always BUFFER_DEPTH - elements_o.
- Flags are combinational from the registered elements: almost_full_o = elements >= ALMOST_FULL_TH; almost_empty_o = elements <= ALMOST_EMPTY_TH.
- overflow_o is set on any cycle with valid_i && full && !clr_i. It is cleared by err_clr_i or clr_i; set has priority over err_clr_i in the same cycle.
- Priority order: rst_i > clr_i > normal operation.
- clr_i resets pointers and elements to 0 and clears overflow_o. Any push or pop offered in that cycle is discarded.
- Storage RAM is not reset. data_o is don't-care while valid_o=0, except in the fall-through case above.

## Timing
- Reset values, after the first clock edge with rst_i=1: elements_o=0, free_o=BUFFER_DEPTH, valid_o=0, ready_o=1, almost_empty_o=1, almost_full_o=(ALMOST_FULL_TH==0), overflow_o=0.
- Reset mid-transfer discards all contents on that edge. No outputs change before the edge.
- Push-to-valid latency: 1 cycle in stored mode; 0 cycles in fall-through mode when empty.
- Pop-to-ready latency: ready_o rises the cycle after a pop from full.
- elements_o and the flags update one cycle after the accepted handshake.
- Single write port and single read port; sustains 1 push + 1 pop per cycle at any occupancy from 1 to BUFFER_DEPTH-1.

## Test plan
- Reset/idle (DEPTH=8): rst_i high for 2 cycles -> elements_o=0, free_o=8, ready_o=1, valid_o=0, almost_empty_o=1, overflow_o=0.
- Fill/drain, DEPTH=5: push 0x11..0x55, then push 0x66 -> ready_o=0, overflow_o=1, 0x66 dropped. Drain -> 0x11..0x55 in order; elements_o goes 5 down to 0; pointers wrap correctly.
- Thresholds (AF_TH=6, AE_TH=2, DEPTH=8): fill one word per cycle -> almost_empty_o drops at elements=3 and almost_full_o rises at elements=6, each one cycle after the handshake.
- Streaming with occupancy 3: simultaneous push and pop for 20 cycles with wrap -> elements_o stays 3 and data_o sequence is preserved.
- Fall-through (FALL_THROUGH=1): empty, valid_i=1, data_i=0xA5, ready_i=1 -> same-cycle valid_o=1, data_o=0xA5, elements_o stays 0. Repeat with ready_i=0 -> elements_o=1 next cycle.
- Flush/clear: 4 entries plus overflow_o=1, assert clr_i together with valid_i -> next cycle elements_o=0, overflow_o=0, push discarded. Separately, err_clr_i concurrent with a new overflow -> overflow_o stays 1.
